twiddle_gen: RTL and testbench

TWIDDLE_GEN -- requirements
Module: twiddle_gen

---
 rtl/fft_pkg.sv | 51 +++++
 rtl/twiddle_rom.sv | 35 +++
 rtl/twiddle_gen.sv | 118 +++++++++++
 tb/tb_twiddle_gen.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared FFT constants, twiddle address mapping and the elaboration-time
// Q1.(TW_W-1) cosine/sine generator used to fill twiddle ROMs.
package fft_pkg;

    localparam int     N_LOG2_DEF = 7;
    localparam int     TW_W_DEF   = 14;
    localparam int     FRAC       = 30;
    localparam longint PI_FX      = 64'sd3373259426;   // pi in Q2.30

    function automatic logic [31:0] tw_addr(input logic [31:0] j, input logic [31:0] s);
        return j << s;
    endfunction

    // One component of W_N^k = cos(2*pi*k/N) - j*sin(2*pi*k/N), N = 2**n_log2,
    // scaled by 2^(tw_w-1)-1 and rounded half away from zero.
    function automatic int tw_comp(input int k, input int n_log2, input int tw_w, input bit want_im);
        int     kk;
        int     n_half;
        int     n_quarter;
        bit     neg;
        longint th;
        longint th2;
        longint term;
        longint acc;
        longint scaled;
        longint half;
        n_half    = 1 << (n_log2 - 1);
        n_quarter = n_half >> 1;
        kk        = k;
        neg       = want_im;
        if (kk > n_quarter) begin
            kk = n_half - kk;
            if (!want_im) neg = 1'b1;
        end
        th   = (PI_FX * longint'(kk)) >>> (n_log2 - 1);
        th2  = (th * th) >>> FRAC;
        term = want_im ? th : (64'sd1 <<< FRAC);
        acc  = term;
        for (int n = 1; n <= 12; n++) begin
            term = -((term * th2) >>> FRAC) /
                   longint'(want_im ? (2 * n) * (2 * n + 1) : (2 * n - 1) * (2 * n));
            acc  = acc + term;
        end
        half   = 64'sd1 <<< (FRAC - 1);
        scaled = acc * longint'((1 << (tw_w - 1)) - 1);
        if (scaled >= 0) scaled = (scaled + half) >>> FRAC;
        else             scaled = -((-scaled + half) >>> FRAC);
        return int'(neg ? -scaled : scaled);
    endfunction

endpackage

// File: rtl/twiddle_rom.sv
// Registered-read twiddle ROM holding W_N^a (a = 0..DEPTH-1, N = 2**N_LOG2) packed {re, im}.
// Contents are computed at elaboration; INIT_FILE names the matching hex image.
module twiddle_rom
    import fft_pkg::*;
#(
    parameter int DEPTH     = 64,
    parameter int WIDTH     = 28,
    parameter int N_LOG2    = 7,
    parameter     INIT_FILE = "twiddle.hex"
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     en_i,
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    output logic [WIDTH-1:0]         rd_o
);
    localparam int CW = WIDTH / 2;

    logic [WIDTH-1:0] tbl [DEPTH];
    logic [WIDTH-1:0] rd_q;

    for (genvar a = 0; a < DEPTH; a++) begin : g_tbl
        localparam int RE = tw_comp(a, N_LOG2, CW, 1'b0);
        localparam int IM = tw_comp(a, N_LOG2, CW, 1'b1);
        assign tbl[a] = {CW'(RE), CW'(IM)};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)   rd_q <= '0;
        else if (en_i) rd_q <= tbl[addr_i];
    end

    assign rd_o = rd_q;

endmodule

// File: rtl/twiddle_gen.sv
// Streaming FFT twiddle source: k = (j << s) mod N/2, two-stage pipeline, latency 2.
// Define TWIDDLE_QUARTER_WAVE_EN to build from an N/4-entry ROM plus a quadrant swap.
module twiddle_gen
    import fft_pkg::*;
#(
    parameter int N_LOG2    = N_LOG2_DEF,
    parameter int TW_W      = TW_W_DEF,
    parameter     INIT_FILE = "twiddle.hex"
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [$clog2(N_LOG2)-1:0] stage_in,
    input  logic                      req_valid,
    output logic                      req_ready,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [TW_W-1:0]           tw_re,
    output logic [TW_W-1:0]           tw_im,
    output logic [N_LOG2-2:0]         tw_idx,
    output logic                      last
);
    localparam int KW = N_LOG2 - 1;
    localparam int SW = $clog2(N_LOG2);
`ifdef TWIDDLE_QUARTER_WAVE_EN
    localparam int DEPTH = 1 << (N_LOG2 - 2);
`else
    localparam int DEPTH = 1 << (N_LOG2 - 1);
`endif
    localparam int AW = $clog2(DEPTH);

    logic [KW-1:0]     j_q;
    logic [SW-1:0]     s_q;
    logic [SW-1:0]     s_d;
    logic [KW-1:0]     k_d;
    logic [KW-1:0]     k1_q;
    logic [KW-1:0]     k2_q;
    logic              v1_q;
    logic              v2_q;
    logic              last1_q;
    logic              last2_q;
    logic              en;
    logic              accept;
    logic [2*TW_W-1:0] rom_rd;
    logic [TW_W-1:0]   rom_re;
    logic [TW_W-1:0]   rom_im;

    assign en        = !v2_q || out_ready;
    assign req_ready = en && !start;
    assign accept    = req_valid && req_ready;
    assign s_d       = (32'(stage_in) >= N_LOG2) ? SW'(N_LOG2 - 1) : stage_in;
    assign k_d       = KW'(tw_addr(32'(j_q), 32'(s_q)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            j_q     <= '0;
            s_q     <= '0;
            v1_q    <= 1'b0;
            k1_q    <= '0;
            last1_q <= 1'b0;
            v2_q    <= 1'b0;
            k2_q    <= '0;
            last2_q <= 1'b0;
        end else if (start) begin
            s_q  <= s_d;
            j_q  <= '0;
            v1_q <= 1'b0;
            v2_q <= 1'b0;
        end else if (en) begin
            v1_q    <= accept;
            last1_q <= accept && (&j_q);
            if (accept) begin
                k1_q <= k_d;
                j_q  <= j_q + 1'b1;
            end
            v2_q    <= v1_q;
            k2_q    <= k1_q;
            last2_q <= last1_q;
        end
    end

    twiddle_rom #(
        .DEPTH    (DEPTH),
        .WIDTH    (2 * TW_W),
        .N_LOG2   (N_LOG2),
        .INIT_FILE(INIT_FILE)
    ) u_rom (
        .clk_i (clk),
        .rst_ni(rst),
        .en_i  (en),
        .addr_i(k1_q[AW-1:0]),
        .rd_o  (rom_rd)
    );

    assign rom_re = rom_rd[2*TW_W-1:TW_W];
    assign rom_im = rom_rd[TW_W-1:0];

`ifdef TWIDDLE_QUARTER_WAVE_EN
    logic sel2_q;

    // Only the first quadrant is stored; k >= N/4 is W^(k-N/4) rotated by -j.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)    sel2_q <= 1'b0;
        else if (en) sel2_q <= k1_q[KW-1];
    end

    assign tw_re = sel2_q ? rom_im : rom_re;
    assign tw_im = sel2_q ? -rom_re : rom_im;
`else
    assign tw_re = rom_re;
    assign tw_im = rom_im;
`endif

    assign out_valid = v2_q;
    assign tw_idx    = k2_q;
    assign last      = last2_q;

endmodule

// File: tb/tb_twiddle_gen.sv
// Bench for twiddle_gen (N_LOG2=7, TW_W=14): expected twiddles come from real cos/sin
// and a queue of accepted requests; directed scenarios followed by a random stream.
`timescale 1ns/1ps
module tb_twiddle_gen;
    localparam int NL = 7;
    localparam int TW = 14;
    localparam int NH = 1 << (NL - 1);

    logic          clk       = 1'b0;
    logic          rst       = 1'b0;
    logic          start     = 1'b0;
    logic          req_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [2:0]    stage_in  = 3'd0;
    logic          req_ready;
    logic          out_valid;
    logic          last;
    logic [TW-1:0] tw_re;
    logic [TW-1:0] tw_im;
    logic [NL-2:0] tw_idx;

    typedef struct {
        int k;
        bit lst;
    } word_t;

    int            total     = 0;
    int            bad       = 0;
    int            cyc       = 0;
    int            j_m       = 0;
    int            s_m       = 0;
    int            first_acc = -1;
    int            first_ov  = -1;
    word_t         exp_q[$];
    logic [NL-2:0] seen_idx  = '0;
    logic [TW-1:0] seen_re   = '0;
    logic [TW-1:0] seen_im   = '0;

    always #5 clk = ~clk;

    twiddle_gen #(.N_LOG2(NL), .TW_W(TW), .INIT_FILE("twiddle.hex")) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stage_in (stage_in),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .tw_re    (tw_re),
        .tw_im    (tw_im),
        .tw_idx   (tw_idx),
        .last     (last)
    );

    function automatic int ref_comp(input int k, input bit im);
        real a;
        real v;
        real fs;
        fs = real'((1 << (TW - 1)) - 1);
        a  = 2.0 * 3.14159265358979323846 * real'(k) / real'(2 * NH);
        v  = im ? -fs * $sin(a) : fs * $cos(a);
        if (v >= 0.0) return $rtoi(v + 0.5);
        return -$rtoi(-v + 0.5);
    endfunction

    // One clock: drive inputs, check at the falling edge, advance the reference model.
    task automatic step(input bit rv, input bit ordy, input bit st, input logic [2:0] stg);
        bit            exp_rr;
        word_t         w;
        logic [NL-2:0] ek;
        logic [TW-1:0] ere;
        logic [TW-1:0] eim;
        req_valid = rv;
        out_ready = ordy;
        start     = st;
        stage_in  = stg;
        @(negedge clk);
        exp_rr = (!out_valid || ordy) && !st;
        total++;
        if (req_ready !== exp_rr) begin
            bad++;
            $display("FAIL req_ready cyc=%0d got=%0b want=%0b", cyc, req_ready, exp_rr);
        end
        if (out_valid === 1'b1 && first_ov < 0) first_ov = cyc;
        if (out_valid === 1'b1 && ordy) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL spurious_word cyc=%0d got idx=%0d want no word", cyc, tw_idx);
            end else begin
                w   = exp_q.pop_front();
                ek  = w.k[NL-2:0];
                ere = TW'(ref_comp(w.k, 1'b0));
                eim = TW'(ref_comp(w.k, 1'b1));
                if (tw_idx !== ek || last !== w.lst || tw_re !== ere || tw_im !== eim) begin
                    bad++;
                    $display("FAIL word cyc=%0d got idx=%0d last=%0b re=%h im=%h want idx=%0d last=%0b re=%h im=%h",
                             cyc, tw_idx, last, tw_re, tw_im, ek, w.lst, ere, eim);
                end
                seen_idx = tw_idx;
                seen_re  = tw_re;
                seen_im  = tw_im;
            end
        end
        if (st) begin
            exp_q.delete();
            j_m = 0;
            s_m = (int'(stg) >= NL) ? NL - 1 : int'(stg);
        end else if (rv && exp_rr) begin
            if (first_acc < 0) first_acc = cyc;
            exp_q.push_back('{k: (j_m << s_m) % NH, lst: (j_m == NH - 1)});
            j_m = (j_m + 1) % NH;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid === 1'b1) && n < 20) begin
            step(1'b0, 1'b1, 1'b0, 3'd0);
            n++;
        end
        total++;
        if (exp_q.size() != 0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL drain pending=%0d out_valid=%0b want 0 and 0", exp_q.size(), out_valid);
        end
    endtask

    task automatic test_reset();
        #12;
        total++;
        if ({out_valid, last, tw_re, tw_im, tw_idx} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got v=%0b last=%0b re=%h im=%h idx=%0d want all 0",
                     out_valid, last, tw_re, tw_im, tw_idx);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_stream_s0();
        step(1'b0, 1'b1, 1'b1, 3'd0);
        first_acc = -1;
        first_ov  = -1;
        repeat (NH) step(1'b1, 1'b1, 1'b0, 3'd0);
        drain();
        total++;
        if (first_ov != first_acc + 2) begin
            bad++;
            $display("FAIL latency got=%0d want=%0d", first_ov - first_acc, 2);
        end
        total++;
        if (seen_idx !== 6'd63) begin
            bad++;
            $display("FAIL stream_end_idx got=%0d want=63", seen_idx);
        end
    endtask

    task automatic test_stage_map();
        step(1'b0, 1'b1, 1'b1, 3'd1);
        repeat (34) step(1'b1, 1'b1, 1'b0, 3'd0);
        drain();
        total++;
        if (seen_idx !== 6'd2) begin
            bad++;
            $display("FAIL s1_j33 got idx=%0d want=2", seen_idx);
        end
        step(1'b0, 1'b1, 1'b1, 3'd6);
        repeat ($urandom_range(5, 40)) step(1'b1, 1'b1, 1'b0, 3'd0);
        drain();
        total++;
        if (seen_idx !== 6'd0) begin
            bad++;
            $display("FAIL s6_any_j got idx=%0d want=0", seen_idx);
        end
        step(1'b0, 1'b1, 1'b1, 3'd7);
        repeat (20) step(1'b1, 1'b1, 1'b0, 3'd0);
        drain();
    endtask

    task automatic test_k32();
        step(1'b0, 1'b1, 1'b1, 3'd0);
        repeat (33) step(1'b1, 1'b1, 1'b0, 3'd0);
        drain();
        total++;
        if (seen_idx !== 6'd32 || seen_re !== 14'h0000 || seen_im !== 14'h2001) begin
            bad++;
            $display("FAIL k32 got idx=%0d re=%h im=%h want idx=32 re=0000 im=2001",
                     seen_idx, seen_re, seen_im);
        end
    endtask

    task automatic test_backpressure();
        logic [TW+TW+NL+1-1:0] snap;
        step(1'b0, 1'b1, 1'b1, 3'($urandom_range(0, 6)));
        repeat (6) step(1'b1, 1'b1, 1'b0, 3'd0);
        snap = {out_valid, last, tw_re, tw_im, tw_idx};
        total++;
        if (out_valid !== 1'b1) begin
            bad++;
            $display("FAIL stall_entry got out_valid=%0b want=1", out_valid);
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 1'b0, 3'd0);
            total++;
            if ({out_valid, last, tw_re, tw_im, tw_idx} !== snap) begin
                bad++;
                $display("FAIL stall_hold cyc=%0d got=%h want=%h", cyc,
                         {out_valid, last, tw_re, tw_im, tw_idx}, snap);
            end
        end
        repeat (10) step(1'b1, 1'b1, 1'b0, 3'd0);
        drain();
    endtask

    task automatic test_start_abort();
        step(1'b0, 1'b1, 1'b1, 3'd4);
        repeat (10) step(1'b1, 1'b1, 1'b0, 3'd0);
        step(1'b1, 1'b1, 1'b1, 3'd3);
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL start_flush got out_valid=%0b want=0", out_valid);
        end
        step(1'b1, 1'b1, 1'b0, 3'd0);
        drain();
        total++;
        if (seen_idx !== 6'd0) begin
            bad++;
            $display("FAIL start_restart_idx got=%0d want=0", seen_idx);
        end
    endtask

    task automatic test_async_reset();
        step(1'b0, 1'b1, 1'b1, 3'd3);
        repeat (10) step(1'b1, 1'b1, 1'b0, 3'd0);
        #2 rst = 1'b0;
        #1;
        total++;
        if ({out_valid, last, tw_re, tw_im, tw_idx} !== '0) begin
            bad++;
            $display("FAIL async_reset got v=%0b last=%0b re=%h im=%h idx=%0d want all 0",
                     out_valid, last, tw_re, tw_im, tw_idx);
        end
        exp_q.delete();
        j_m = 0;
        s_m = 0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        step(1'b1, 1'b1, 1'b0, 3'd5);
        drain();
        total++;
        if (seen_idx !== 6'd0 || seen_re !== 14'h1FFF || seen_im !== 14'h0000) begin
            bad++;
            $display("FAIL reset_restart got idx=%0d re=%h im=%h want idx=0 re=1fff im=0000",
                     seen_idx, seen_re, seen_im);
        end
        repeat (12) step(1'b1, 1'b1, 1'b0, 3'd0);
        drain();
    endtask

    task automatic test_random();
        step(1'b0, 1'b1, 1'b1, 3'($urandom_range(0, 7)));
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 40) == 0, 3'($urandom_range(0, 7)));
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_stream_s0();
        test_stage_map();
        test_k32();
        test_backpressure();
        test_start_abort();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
